pll_phase_step_ctrl: RTL and testbench
======================================

Name: pll_phase_step_ctrl

Overview:
Sequencer for the ECP5 EHXPLLL dynamic phase-adjust pins (PHASESEL, PHASEDIR, PHASESTEP). It accepts a request (output select, direction, step count) over a valid/ready handshake and drives the PLL pins with the required setup, pulse-width and hold timing. After the last step it waits for PLL lock to restabilise, then reports done or error. It sits beside the system PLL wrapper, clocked from the free-running 25 MHz I/O clock, and is driven by the CPU's memory-mapped I/O block for DDR/SDRAM and video phase tuning.

Parameters:
SETUP_CYCLES, 4, cycles phasesel/phasedir are held stable before the first step pulse
PULSE_CYCLES, 4, cycles phasestep is held low per step
HOLD_CYCLES, 4, cycles phasestep is held high between steps and after the last step
STEP_W, 8, width of the step count
LOCK_STABLE, 16, consecutive synchronised-lock cycles required before done
LOCK_TIMEOUT, 65535, maximum SETTLE cycles before error (16-bit counter)

Ports:
clock  in  1  single clock (25 MHz I/O clock)
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_sel  in  2  PLL output to shift: 0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3
req_dir  in  1  0=lag (delay), 1=lead (advance)
req_steps  in  STEP_W  number of phase steps; 0 is legal
pll_locked  in  1  PLL LOCK, asynchronous to clock
phasesel  out  2  to PLL PHASESEL[1:0]
phasedir  out  1  to PLL PHASEDIR
phasestep  out  1  to PLL PHASESTEP, idle high, active low
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on successful completion
error  out  1  sticky; set on lock timeout, cleared on next accepted request or reset
steps_left  out  STEP_W  remaining steps, for status readback

Behaviour:
- Reset values: state IDLE, req_ready=1 (from the first cycle after reset deasserts), phasesel=0, phasedir=0, phasestep=1, busy=0, done=0, error=0, steps_left=0, lock synchroniser=0.
- pll_locked passes through a 2-flop synchroniser (lock_s). All lock decisions use lock_s.
- req_ready = (state==IDLE) && !reset. Accept when req_valid && req_ready. On accept, latch sel/dir/steps, clear error, go to SETUP.
- SETUP: phasesel/phasedir driven from latched values, phasestep=1, for exactly SETUP_CYCLES cycles. Then, if steps_left==0, go to SETTLE; otherwise go to PULSE.
- PULSE: phasestep=0 for PULSE_CYCLES cycles, then HOLD.
- HOLD: phasestep=1 for HOLD_CYCLES cycles. On the last HOLD cycle, decrement steps_left. If the new value is nonzero, go to PULSE; otherwise go to SETTLE.
- phasesel and phasedir change only on accept. They are held constant from SETUP through SETTLE and keep their values in IDLE until the next accept.
- SETTLE: count consecutive lock_s=1 cycles; reset the count to 0 on any lock_s=0. At LOCK_STABLE, pulse done for one cycle and go to IDLE. If LOCK_TIMEOUT cycles elapse in SETTLE first, set error, leave done=0, and go to IDLE.
- The step count uses modular decrement and never underflows, because 0 bypasses PULSE.
- Latency for N>0 steps, with lock already stable: accept cycle +1, then SETUP_CYCLES + N*(PULSE_CYCLES+HOLD_CYCLES) + LOCK_STABLE cycles to the done pulse. For N=0: SETUP_CYCLES + LOCK_STABLE.
- req_valid asserted while busy is ignored; the requester holds it until ready.
- Lock loss during PULSE/HOLD is ignored; only SETTLE checks lock.
- Reset mid-operation: all outputs return to reset values on the next edge. phasestep is forced high immediately, so no truncated low pulse continues beyond the reset edge.

Decomposition:
- Package pll_phase_pkg holds:
  - state enum: IDLE, SETUP, PULSE, HOLD, SETTLE
  - PLL output select constants: SEL_CLKOP=0 … SEL_CLKOS3=3
  - direction constants: DIR_LAG=0, DIR_LEAD=1
- One sub-module, sync2: a generic 2-flop synchroniser for pll_locked.
- A single shared cycle counter serves SETUP/PULSE/HOLD/SETTLE timing.

Test Plan:
- Reset then idle, pll_locked=1 → phasestep=1, req_ready=1, busy=0 held for 100 cycles.
- Request sel=1, dir=1, steps=3 → phasesel=1, phasedir=1 from the cycle after accept; exactly 3 low pulses of 4 cycles separated by 4 high cycles; done at 1+4+24+16 cycles after accept; steps_left 3→2→1→0.
- Request steps=0 → no phasestep low at all; done at 1+4+16 cycles after accept.
- pll_locked held 0 through SETTLE (LOCK_TIMEOUT overridden to 100) → error=1, no done pulse, IDLE. Next request clears error.
- Glitchy lock: lock drops for 1 cycle at SETTLE cycle 10 → stable count restarts and done is delayed accordingly. Second request during busy → ignored, accepted only once req_ready returns.
- Reset asserted during the 2nd PULSE of a steps=5 request → next edge: phasestep=1, state IDLE, steps_left=0, no done.

Source files
------------

// File: rtl/pll_phase_pkg.sv
// pll_phase_pkg: shared types and constants for the PLL phase-step controller.
// Ports: none (package only).
package pll_phase_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, SETTLE} state_t;
    localparam logic [1:0] SEL_CLKOP  = 2'd0;
    localparam logic [1:0] SEL_CLKOS  = 2'd1;
    localparam logic [1:0] SEL_CLKOS2 = 2'd2;
    localparam logic [1:0] SEL_CLKOS3 = 2'd3;
    localparam logic DIR_LAG  = 1'b0;
    localparam logic DIR_LEAD = 1'b1;
endpackage

// File: rtl/pll_phase_step_ctrl_sync2.sv
// sync2: generic two-flop synchroniser with synchronous reset to 0.
// Ports: i_clock, i_reset (sync, active high), i_d (async input), o_q (synchronised output).
module sync2 (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_sync;
    always_ff @(posedge i_clock) begin
        r_sync <= i_reset ? 2'b00 : {r_sync[0], i_d};
    end
    assign o_q = r_sync[1];
endmodule

// File: rtl/pll_phase_step_ctrl.sv
// pll_phase_step_ctrl: sequences ECP5 EHXPLLL PHASESEL/PHASEDIR/PHASESTEP for a requested step count.
// Ports: i_clock, i_reset (sync, active high); request i_req_valid/o_req_ready with i_req_sel,
// i_req_dir, i_req_steps; i_pll_locked (async); PLL pins o_phasesel, o_phasedir, o_phasestep;
// status o_busy, o_done (1-cycle pulse), o_error (sticky lock timeout), o_steps_left.
module pll_phase_step_ctrl
    import pll_phase_pkg::*;
#(
    parameter int SETUP_CYCLES = 4,
    parameter int PULSE_CYCLES = 4,
    parameter int HOLD_CYCLES  = 4,
    parameter int STEP_W       = 8,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        i_req_sel,
    input  logic              i_req_dir,
    input  logic [STEP_W-1:0] i_req_steps,
    input  logic              i_pll_locked,
    output logic [1:0]        o_phasesel,
    output logic              o_phasedir,
    output logic              o_phasestep,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [STEP_W-1:0] o_steps_left
);
    localparam int SW = $clog2(LOCK_STABLE + 1);

    state_t            r_state;
    logic [15:0]       r_cnt;
    logic [SW-1:0]     r_stable;
    logic [1:0]        r_sel;
    logic              r_dir;
    logic              r_step;
    logic              r_done;
    logic              r_error;
    logic [STEP_W-1:0] r_left;
    logic              w_lock_s;
    logic              w_last;

    sync2 u_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (i_pll_locked),
        .o_q     (w_lock_s)
    );

    // One counter times every phase; in SETTLE it measures elapsed time for the timeout.
    assign w_last = r_cnt == ((r_state == SETUP) ? 16'(SETUP_CYCLES - 1) :
                              (r_state == PULSE) ? 16'(PULSE_CYCLES - 1) :
                              (r_state == HOLD)  ? 16'(HOLD_CYCLES - 1)  :
                                                   16'(LOCK_TIMEOUT - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_stable <= '0;
            r_sel    <= '0;
            r_dir    <= 1'b0;
            r_step   <= 1'b1;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_left   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (i_req_valid) begin
                    r_state <= SETUP;
                    r_sel   <= i_req_sel;
                    r_dir   <= i_req_dir;
                    r_left  <= i_req_steps;
                    r_error <= 1'b0;
                    r_cnt   <= '0;
                end
                SETUP: begin
                    r_cnt <= w_last ? '0 : r_cnt + 16'd1;
                    if (w_last) begin
                        r_stable <= '0;
                        r_state  <= (r_left == '0) ? SETTLE : PULSE;
                        r_step   <= (r_left == '0);
                    end
                end
                PULSE: begin
                    r_cnt <= w_last ? '0 : r_cnt + 16'd1;
                    if (w_last) begin
                        r_state <= HOLD;
                        r_step  <= 1'b1;
                    end
                end
                HOLD: begin
                    r_cnt <= w_last ? '0 : r_cnt + 16'd1;
                    if (w_last) begin
                        // A zero count never reaches here, so the decrement cannot wrap.
                        r_left   <= r_left - STEP_W'(1);
                        r_stable <= '0;
                        r_state  <= (r_left == STEP_W'(1)) ? SETTLE : PULSE;
                        r_step   <= (r_left == STEP_W'(1));
                    end
                end
                SETTLE: begin
                    if (w_lock_s && r_stable == SW'(LOCK_STABLE - 1)) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_last) begin
                        r_error <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt    <= r_cnt + 16'd1;
                        r_stable <= w_lock_s ? r_stable + SW'(1) : '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready  = (r_state == IDLE) && !i_reset;
    assign o_busy       = r_state != IDLE;
    // Reset releases PHASESTEP at once so a low pulse is never cut short mid-edge.
    assign o_phasestep  = r_step | i_reset;
    assign o_phasesel   = r_sel;
    assign o_phasedir   = r_dir;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_steps_left = r_left;
endmodule

// File: tb/tb_pll_phase_step_ctrl.sv
// tb_pll_phase_step_ctrl: scoreboard bench for the PLL phase-step controller.
module tb_pll_phase_step_ctrl;
    import pll_phase_pkg::*;
    localparam int SU = 4, PW = 4, HW = 4, LS = 16, TO = 100;

    logic       clk = 1'b0, rst = 1'b1, valid = 1'b0, dir = 1'b0, locked = 1'b1;
    logic [1:0] sel = 2'd0;
    logic [7:0] steps = 8'd0;
    logic       ready, ps_dir, ps_step, busy, done, err;
    logic [1:0] ps_sel;
    logic [7:0] left;

    pll_phase_step_ctrl #(
        .SETUP_CYCLES (SU),
        .PULSE_CYCLES (PW),
        .HOLD_CYCLES  (HW),
        .STEP_W       (8),
        .LOCK_STABLE  (LS),
        .LOCK_TIMEOUT (TO)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_req_valid  (valid),
        .o_req_ready  (ready),
        .i_req_sel    (sel),
        .i_req_dir    (dir),
        .i_req_steps  (steps),
        .i_pll_locked (locked),
        .o_phasesel   (ps_sel),
        .o_phasedir   (ps_dir),
        .o_phasestep  (ps_step),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (err),
        .o_steps_left (left)
    );

    always #20 clk = ~clk;

    typedef struct {
        int         kind;
        int         at_edge;
        logic [1:0] sel;
        logic       dir;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0, vecs = 0, errs = 0, acc_edge = -1, acc_cnt = 0;
    int   exp_kind = 0, exp_lat = 0, exp_left = 0, lowrun = 0, npulses = 0;
    logic prev_err = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        vecs++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Edge process: records accepts and pushes the hand-computed completion.
    always @(posedge clk) begin
        if (!rst && valid && ready) begin
            acc_edge <= cyc;
            acc_cnt  <= acc_cnt + 1;
            exp_left <= int'(steps);
            if (exp_kind != 2) q.push_back('{exp_kind, cyc + exp_lat, sel, dir});
        end
        cyc <= cyc + 1;
    end

    // Monitor: pulse shape and step countdown, plus scoreboard pops on done/error.
    always @(negedge clk) begin
        if (rst) begin
            lowrun <= 0;
        end else if (!ps_step) begin
            lowrun <= lowrun + 1;
        end else if (lowrun > 0) begin
            chk("pulse_width", lowrun, PW);
            chk("steps_left_in_hold", int'(left), exp_left);
            exp_left <= exp_left - 1;
            npulses  <= npulses + 1;
            lowrun   <= 0;
        end
        if (!rst && (done || (err && !prev_err))) begin
            if (q.size() == 0) begin
                chk("unexpected_completion", 1, 0);
            end else begin
                e = q.pop_front();
                chk("completion_kind", done ? 0 : 1, e.kind);
                chk("completion_edge", cyc - 1, e.at_edge);
                chk("phasesel_held", int'(ps_sel), int'(e.sel));
                chk("phasedir_held", int'(ps_dir), int'(e.dir));
                chk("steps_left_end", int'(left), 0);
            end
        end
        prev_err <= err;
    end

    task automatic request(input logic [1:0] s, input logic d, input logic [7:0] n,
                           input int kind, input int lat);
        int c0;
        c0 = acc_cnt;
        sel = s; dir = d; steps = n; exp_kind = kind; exp_lat = lat; valid = 1'b1;
        for (int i = 0; i < 2000 && acc_cnt == c0; i++) @(negedge clk);
        chk("request_accepted", acc_cnt - c0, 1);
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && (q.size() != 0 || busy); i++) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
    endtask

    initial begin
        int a, p0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_phasestep", int'(ps_step), 1);
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(err), 0);
        chk("rst_steps_left", int'(left), 0);
        chk("rst_phasesel", int'(ps_sel), 0);
        chk("rst_phasedir", int'(ps_dir), 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_step_ready_busy", int'({ps_step, ready, busy}), 3'b110);
        end

        // Three steps, lead, CLKOS: 4 + 3*8 + 16 edges to done.
        p0 = npulses;
        request(SEL_CLKOS, DIR_LEAD, 8'd3, 0, SU + 3 * (PW + HW) + LS);
        chk("sel_after_accept", int'(ps_sel), 1);
        chk("dir_after_accept", int'(ps_dir), 1);
        chk("busy_after_accept", int'(busy), 1);
        wait_idle();
        chk("pulse_count_3", npulses - p0, 3);

        // Zero steps: no pulse, 4 + 16 edges to done.
        p0 = npulses;
        request(SEL_CLKOS2, DIR_LAG, 8'd0, 0, SU + LS);
        wait_idle();
        chk("pulse_count_0", npulses - p0, 0);

        // Lock lost through SETTLE: error after 4 + 8 + 100 edges.
        locked = 1'b0;
        repeat (4) @(negedge clk);
        request(SEL_CLKOS3, DIR_LEAD, 8'd1, 1, SU + PW + HW + TO);
        wait_idle();
        chk("error_sticky", int'(err), 1);
        chk("timeout_idle_ready", int'(ready), 1);
        locked = 1'b1;
        repeat (4) @(negedge clk);
        request(SEL_CLKOP, DIR_LAG, 8'd2, 0, SU + 2 * (PW + HW) + LS);
        chk("error_cleared", int'(err), 0);
        wait_idle();

        // Glitch: lock low for the edge at SETTLE cycle 10; stable count restarts,
        // done moves from 20 to 32 edges. A second request waits for ready.
        request(SEL_CLKOS, DIR_LAG, 8'd0, 0, 32);
        a = acc_edge;
        fork
            begin
                while (cyc != a + 14) @(negedge clk);
                locked = 1'b0;
                @(negedge clk);
                locked = 1'b1;
            end
            begin
                request(SEL_CLKOS2, DIR_LEAD, 8'd1, 0, SU + PW + HW + LS);
                chk("busy_request_accept_edge", acc_edge, a + 33);
            end
        join
        wait_idle();

        // Reset in the second low pulse of a five-step request.
        request(SEL_CLKOS3, DIR_LEAD, 8'd5, 2, 0);
        a = acc_edge;
        while (cyc != a + 14) @(negedge clk);
        chk("second_pulse_low", int'(ps_step), 0);
        rst = 1'b1;
        #1;
        chk("reset_forces_step_high", int'(ps_step), 1);
        @(negedge clk);
        chk("midrst_phasestep", int'(ps_step), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_steps_left", int'(left), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_ready_in_reset", int'(ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_ready", int'(ready), 1);
        chk("postrst_phasesel", int'(ps_sel), 0);
        chk("postrst_phasedir", int'(ps_dir), 0);
        repeat (60) @(negedge clk);
        chk("queue_empty_end", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
